// File: rtl/oc_pkg.sv
// Shared types and constants for the operand-collector bank arbiter.
// Register index layout: bank in [1:0], row in [4:2].
package oc_pkg;
  localparam int NUM_UNITS = 4;
  localparam int NUM_BANKS = 4;
  localparam int OCID_W    = 3;
  localparam int NUM_REQ   = 2 * NUM_UNITS;
  localparam int IDX_W     = 3;
  localparam int REG_W     = 5;
  localparam int BANK_LSB  = 0;
  localparam int BANK_W    = 2;
  localparam int ROW_LSB   = 2;
  localparam int ROW_W     = 3;

  typedef logic [BANK_W-1:0] bank_t;
  typedef logic [ROW_W-1:0]  row_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] unit;
    logic       slot;
  } ocid_t;

  function automatic bank_t reg_bank(input logic [REG_W-1:0] r);
    return r[BANK_LSB +: BANK_W];
  endfunction

  function automatic row_t reg_row(input logic [REG_W-1:0] r);
    return r[ROW_LSB +: ROW_W];
  endfunction
endpackage

// File: rtl/oc_rr_arb8.sv
// 8-request round-robin picker: first request at or after ptr, wrapping 7->0.
// Purely combinational; no flow control of its own.
module oc_rr_arb8
  import oc_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = ptr;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    gnt[idx] = any;
  end

endmodule

// File: rtl/oc_bank_arbiter.sv
// Allocates instructions to collector units and round-robins bank reads; grant tag/row registered (1 cycle).
// Alloc_Rdy low when all units busy; RF_WR_b blocks bank b for that cycle.
module oc_bank_arbiter
  import oc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             Valid_RAU_Collecting,
  input  logic             Src1_Vld,
  input  logic             Src2_Vld,
  input  logic [REG_W-1:0] Src1_Reg,
  input  logic [REG_W-1:0] Src2_Reg,
  input  logic             RF_WR_0,
  input  logic             RF_WR_1,
  input  logic             RF_WR_2,
  input  logic             RF_WR_3,
  input  logic [3:0]       Issue_Grt,
  output logic             Alloc_Rdy,
  output logic [1:0]       Alloc_Unit,
  output logic             Alloc_Fire,
  output logic [3:0]       ocid_0,
  output logic [3:0]       ocid_1,
  output logic [3:0]       ocid_2,
  output logic [3:0]       ocid_3,
  output logic [2:0]       Rd_Row_0,
  output logic [2:0]       Rd_Row_1,
  output logic [2:0]       Rd_Row_2,
  output logic [2:0]       Rd_Row_3,
  output logic [3:0]       Unit_Rdy
);

  logic [NUM_UNITS-1:0] busy;
  logic [NUM_REQ-1:0]   pend;
  logic [NUM_REQ-1:0]   pend_nxt;
  bank_t                req_bank [NUM_REQ];
  row_t                 req_row  [NUM_REQ];
  logic [IDX_W-1:0]     rr_ptr   [NUM_BANKS];
  ocid_t                ocid_q   [NUM_BANKS];
  row_t                 rd_row_q [NUM_BANKS];

  logic [NUM_BANKS-1:0] rf_wr;
  logic [NUM_REQ-1:0]   bank_req [NUM_BANKS];
  logic [NUM_REQ-1:0]   bank_gnt [NUM_BANKS];
  logic [IDX_W-1:0]     bank_idx [NUM_BANKS];
  logic [NUM_BANKS-1:0] bank_any;
  logic [NUM_REQ-1:0]   gnt_all;
  logic [NUM_UNITS-1:0] alloc_oh;
  logic [NUM_UNITS-1:0] inflight;

  assign rf_wr = {RF_WR_3, RF_WR_2, RF_WR_1, RF_WR_0};

  // Allocation: lowest free unit, based on registered busy only.
  always_comb begin
    Alloc_Unit = '0;
    for (int u = NUM_UNITS - 1; u >= 0; u--) begin
      if (!busy[u]) Alloc_Unit = 2'(u);
    end
  end

  assign Alloc_Rdy  = ~&busy;
  assign Alloc_Fire = Valid_RAU_Collecting & Alloc_Rdy;

  always_comb begin
    alloc_oh = '0;
    alloc_oh[Alloc_Unit] = Alloc_Fire;
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_req[b] = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        bank_req[b][i] = pend[i] && (req_bank[i] == bank_t'(b)) && !rf_wr[b];
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_arb
    oc_rr_arb8 u_arb (
      .req (bank_req[b]),
      .ptr (rr_ptr[b]),
      .gnt (bank_gnt[b]),
      .idx (bank_idx[b]),
      .any (bank_any[b])
    );
  end

  always_comb begin
    gnt_all = '0;
    for (int b = 0; b < NUM_BANKS; b++) gnt_all = gnt_all | bank_gnt[b];
  end

  // A freshly allocated unit has no pending grants, so its slots can be overwritten.
  always_comb begin
    pend_nxt = pend & ~gnt_all;
    if (Alloc_Fire) begin
      pend_nxt[{Alloc_Unit, 1'b0}] = Src1_Vld;
      pend_nxt[{Alloc_Unit, 1'b1}] = Src2_Vld;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      pend <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        req_bank[i] <= '0;
        req_row[i]  <= '0;
      end
    end else begin
      busy <= (busy & ~Issue_Grt) | alloc_oh;
      pend <= pend_nxt;
      if (Alloc_Fire) begin
        req_bank[{Alloc_Unit, 1'b0}] <= reg_bank(Src1_Reg);
        req_row[{Alloc_Unit, 1'b0}]  <= reg_row(Src1_Reg);
        req_bank[{Alloc_Unit, 1'b1}] <= reg_bank(Src2_Reg);
        req_row[{Alloc_Unit, 1'b1}]  <= reg_row(Src2_Reg);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        ocid_q[b]   <= '0;
        rd_row_q[b] <= '0;
        rr_ptr[b]   <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (bank_any[b]) begin
          ocid_q[b].valid <= 1'b1;
          ocid_q[b].unit  <= bank_idx[b][2:1];
          ocid_q[b].slot  <= bank_idx[b][0];
          rd_row_q[b]     <= req_row[bank_idx[b]];
          rr_ptr[b]       <= bank_idx[b] + IDX_W'(1);
        end else begin
          ocid_q[b] <= '0;
        end
      end
    end
  end

  // A unit is not ready while its last operand is still being read out.
  always_comb begin
    inflight = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (ocid_q[b].valid) inflight[ocid_q[b].unit] = 1'b1;
    end
  end

  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      Unit_Rdy[u] = busy[u] & ~pend[2*u] & ~pend[2*u+1] & ~inflight[u];
    end
  end

  assign ocid_0   = ocid_q[0];
  assign ocid_1   = ocid_q[1];
  assign ocid_2   = ocid_q[2];
  assign ocid_3   = ocid_q[3];
  assign Rd_Row_0 = rd_row_q[0];
  assign Rd_Row_1 = rd_row_q[1];
  assign Rd_Row_2 = rd_row_q[2];
  assign Rd_Row_3 = rd_row_q[3];

endmodule

// File: tb/tb_oc_bank_arbiter.sv
// Directed bench for oc_bank_arbiter with hand-computed expectations.
module tb_oc_bank_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       Valid_RAU_Collecting;
  logic       Src1_Vld, Src2_Vld;
  logic [4:0] Src1_Reg, Src2_Reg;
  logic       RF_WR_0, RF_WR_1, RF_WR_2, RF_WR_3;
  logic [3:0] Issue_Grt;
  logic       Alloc_Rdy, Alloc_Fire;
  logic [1:0] Alloc_Unit;
  logic [3:0] ocid_0, ocid_1, ocid_2, ocid_3;
  logic [2:0] Rd_Row_0, Rd_Row_1, Rd_Row_2, Rd_Row_3;
  logic [3:0] Unit_Rdy;

  int n_checks = 0;
  int n_fail   = 0;

  oc_bank_arbiter dut (
    .clk(clk), .rst(rst),
    .Valid_RAU_Collecting(Valid_RAU_Collecting),
    .Src1_Vld(Src1_Vld), .Src2_Vld(Src2_Vld),
    .Src1_Reg(Src1_Reg), .Src2_Reg(Src2_Reg),
    .RF_WR_0(RF_WR_0), .RF_WR_1(RF_WR_1), .RF_WR_2(RF_WR_2), .RF_WR_3(RF_WR_3),
    .Issue_Grt(Issue_Grt),
    .Alloc_Rdy(Alloc_Rdy), .Alloc_Unit(Alloc_Unit), .Alloc_Fire(Alloc_Fire),
    .ocid_0(ocid_0), .ocid_1(ocid_1), .ocid_2(ocid_2), .ocid_3(ocid_3),
    .Rd_Row_0(Rd_Row_0), .Rd_Row_1(Rd_Row_1), .Rd_Row_2(Rd_Row_2), .Rd_Row_3(Rd_Row_3),
    .Unit_Rdy(Unit_Rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 1ns after it; issuing a non-ready unit is flagged.
  task automatic tick();
    if (Issue_Grt != 4'b0000) chk("issue_legal", 8'(Issue_Grt & ~Unit_Rdy), 8'h00);
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v1, input logic [4:0] r1, input logic v2, input logic [4:0] r2);
    Valid_RAU_Collecting = 1'b1;
    Src1_Vld = v1; Src1_Reg = r1;
    Src2_Vld = v2; Src2_Reg = r2;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    Valid_RAU_Collecting = 1'b0;
    Src1_Vld = 1'b0; Src2_Vld = 1'b0; Src1_Reg = '0; Src2_Reg = '0;
    RF_WR_0 = 1'b0; RF_WR_1 = 1'b0; RF_WR_2 = 1'b0; RF_WR_3 = 1'b0;
    Issue_Grt = '0;
    #2;
    chk("rst_ocid0", 8'(ocid_0), 8'h00);
    chk("rst_ocid3", 8'(ocid_3), 8'h00);
    chk("rst_row1", 8'(Rd_Row_1), 8'h00);
    chk("rst_unit_rdy", 8'(Unit_Rdy), 8'h00);
    chk("rst_alloc_rdy", 8'(Alloc_Rdy), 8'h01);
    chk("rst_alloc_unit", 8'(Alloc_Unit), 8'h00);
    #10;
    rst = 1'b0;
    @(posedge clk); #1;

    // Two sources on different banks: R4 (bank0,row1), R9 (bank1,row2).
    offer(1'b1, 5'd4, 1'b1, 5'd9);
    #1;
    chk("t1_fire", 8'(Alloc_Fire), 8'h01);
    chk("t1_unit", 8'(Alloc_Unit), 8'h00);
    tick();
    Valid_RAU_Collecting = 1'b0;
    chk("t1_e0_ocid0", 8'(ocid_0), 8'h00);
    tick();
    chk("t1_e1_ocid0", 8'(ocid_0), 8'h08);
    chk("t1_e1_row0", 8'(Rd_Row_0), 8'h01);
    chk("t1_e1_ocid1", 8'(ocid_1), 8'h09);
    chk("t1_e1_row1", 8'(Rd_Row_1), 8'h02);
    chk("t1_e1_rdy", 8'(Unit_Rdy), 8'h00);
    tick();
    chk("t1_e2_rdy", 8'(Unit_Rdy), 8'h01);
    chk("t1_e2_ocid0", 8'(ocid_0), 8'h00);
    chk("t1_e2_row0_hold", 8'(Rd_Row_0), 8'h01);

    // Both sources on bank 0: serialized slot 0 then slot 1.
    pulse_reset();
    offer(1'b1, 5'd0, 1'b1, 5'd4);
    tick();
    Valid_RAU_Collecting = 1'b0;
    tick();
    chk("t2_e1_ocid0", 8'(ocid_0), 8'h08);
    chk("t2_e1_row0", 8'(Rd_Row_0), 8'h00);
    chk("t2_e1_ocid1", 8'(ocid_1), 8'h00);
    tick();
    chk("t2_e2_ocid0", 8'(ocid_0), 8'h09);
    chk("t2_e2_row0", 8'(Rd_Row_0), 8'h01);
    chk("t2_e2_ocid1", 8'(ocid_1), 8'h00);
    chk("t2_e2_rdy", 8'(Unit_Rdy), 8'h00);
    tick();
    chk("t2_e3_rdy", 8'(Unit_Rdy), 8'h01);

    // Four back-to-back allocations, all on bank 2; request i uses row i.
    pulse_reset();
    for (int k = 0; k < 9; k++) begin
      if (k < 4) begin
        chk("t3_alloc_rdy", 8'(Alloc_Rdy), 8'h01);
        chk("t3_alloc_unit", 8'(Alloc_Unit), 8'(k));
        offer(1'b1, 5'((2 * k) * 4 + 2), 1'b1, 5'((2 * k + 1) * 4 + 2));
      end else if (k == 4) begin
        offer(1'b1, 5'd2, 1'b1, 5'd6);
        #1;
        chk("t3_full_fire", 8'(Alloc_Fire), 8'h00);
      end else begin
        Valid_RAU_Collecting = 1'b0;
      end
      tick();
      if (k == 0) chk("t3_ocid2_e0", 8'(ocid_2), 8'h00);
      else begin
        chk("t3_ocid2", 8'(ocid_2), 8'(8 + k - 1));
        chk("t3_row2", 8'(Rd_Row_2), 8'(k - 1));
      end
      if (k == 3) chk("t3_full_rdy", 8'(Alloc_Rdy), 8'h00);
    end
    Valid_RAU_Collecting = 1'b0;
    tick();
    chk("t3_all_rdy", 8'(Unit_Rdy), 8'h0F);
    chk("t3_ocid2_idle", 8'(ocid_2), 8'h00);

    // Writeback holds bank 3 for three cycles; R7 = bank3,row1.
    pulse_reset();
    RF_WR_3 = 1'b1;
    offer(1'b1, 5'd7, 1'b0, 5'd0);
    tick();
    Valid_RAU_Collecting = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t4_blocked", 8'(ocid_3), 8'h00);
    end
    RF_WR_3 = 1'b0;
    tick();
    chk("t4_ocid3", 8'(ocid_3), 8'h08);
    chk("t4_row3", 8'(Rd_Row_3), 8'h01);
    tick();
    chk("t4_rdy", 8'(Unit_Rdy), 8'h01);

    // Release unit 0 while a new instruction arrives: it goes to unit 1.
    Issue_Grt = 4'b0001;
    offer(1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    chk("t5_unit", 8'(Alloc_Unit), 8'h01);
    chk("t5_fire", 8'(Alloc_Fire), 8'h01);
    tick();
    Issue_Grt = 4'b0000;
    chk("t5_rdy1", 8'(Unit_Rdy), 8'h02);
    chk("t5_next_unit", 8'(Alloc_Unit), 8'h00);
    tick();
    Valid_RAU_Collecting = 1'b0;
    chk("t5_rdy01", 8'(Unit_Rdy), 8'h03);
    chk("t5_after_unit", 8'(Alloc_Unit), 8'h02);

    // Three requests left pending (bank 0 blocked), then async reset.
    RF_WR_0 = 1'b1;
    offer(1'b1, 5'd5, 1'b1, 5'd0);
    tick();
    offer(1'b1, 5'd8, 1'b1, 5'd9);
    tick();
    Valid_RAU_Collecting = 1'b0;
    chk("t6_ocid1", 8'(ocid_1), 8'h0C);
    chk("t6_pend", 8'(dut.pend), 8'hE0);
    rst = 1'b1;
    #1;
    chk("t6_rst_ocid1", 8'(ocid_1), 8'h00);
    chk("t6_rst_rdy", 8'(Unit_Rdy), 8'h00);
    chk("t6_rst_busy", 8'(dut.busy), 8'h00);
    chk("t6_rst_pend", 8'(dut.pend), 8'h00);
    rst = 1'b0;
    RF_WR_0 = 1'b0;
    offer(1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    chk("t6_unit", 8'(Alloc_Unit), 8'h00);
    tick();
    Valid_RAU_Collecting = 1'b0;
    chk("t6_rdy", 8'(Unit_Rdy), 8'h01);
    tick();
    chk("t6_no_replay0", 8'(ocid_0), 8'h00);
    chk("t6_no_replay1", 8'(ocid_1), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
